// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one single-port SRAM between the fetch port and the
// MEM-stage load/store port. Each access is held for WAIT_STATES extra cycles.
// MEM wins ties, but a MEM ack cycle excludes MEM, so a waiting fetch always
// gets the next grant. A fetch that sees a flush while in flight still runs on
// the SRAM, but its ack is suppressed.
module sram_bus_arbiter #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_sel_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] LP_WAIT = 2'(WAIT_STATES);

  state_t      r_state;
  logic        r_owner_mem;  // 1 = MEM owns the current access, 0 = IF
  logic        r_cancel;     // in-flight fetch was flushed; suppress its ack
  logic [1:0]  r_cnt;        // cycles left before the ack cycle
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic w_busy;
  logic w_ack_cycle;
  logic w_arb;
  logic w_mem_elig;
  logic w_if_elig;
  logic w_grant_mem;
  logic w_grant_if;

  // NOTE: reset is synchronous, so during the rst cycle the state registers
  // still hold the old access; every output is qualified with !rst so an
  // abandoned access can neither ack nor strobe a write in that cycle.
  assign w_busy      = (r_state == S_BUSY) && !rst;
  assign w_ack_cycle = w_busy && (r_cnt == 2'd0);

  // Arbitrate when idle or while the current access is finishing.
  assign w_arb       = ((r_state == S_IDLE) || w_ack_cycle) && !flush_i && !rst;
  assign w_mem_elig  = mem_req_i && !(w_ack_cycle && r_owner_mem);
  assign w_if_elig   = if_req_i && !(w_ack_cycle && !r_owner_mem);
  assign w_grant_mem = w_arb && w_mem_elig;
  assign w_grant_if  = w_arb && w_if_elig && !w_mem_elig;

  assign sram_ce_o    = w_busy;
  assign sram_we_o    = w_ack_cycle && r_we;
  assign sram_sel_o   = w_busy ? r_sel   : 4'h0;
  assign sram_addr_o  = w_busy ? r_addr  : 32'h0;
  assign sram_wdata_o = w_busy ? r_wdata : 32'h0;

  assign if_ack_o    = w_ack_cycle && !r_owner_mem && !r_cancel && !flush_i;
  assign mem_ack_o   = w_ack_cycle && r_owner_mem;
  assign if_rdata_o  = if_ack_o ? sram_rdata_i : 32'h0;
  assign mem_rdata_o = (mem_ack_o && !r_we) ? sram_rdata_i : 32'h0;

  assign stallreq_if_o  = if_req_i && !if_ack_o && !rst;
  assign stallreq_mem_o = mem_req_i && !mem_ack_o && !rst;

  // Access sequencer: grant latches the request, BUSY counts down to the ack.
  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_mem <= 1'b0;
      r_cancel    <= 1'b0;
      r_cnt       <= 2'd0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
    end else if (w_grant_mem || w_grant_if) begin
      r_state     <= S_BUSY;
      r_owner_mem <= w_grant_mem;
      r_cancel    <= 1'b0;
      r_cnt       <= LP_WAIT;
      r_we        <= w_grant_mem && mem_we_i;
      r_sel       <= w_grant_mem ? mem_sel_i   : 4'b1111;
      r_addr      <= w_grant_mem ? mem_addr_i  : if_addr_i;
      r_wdata     <= w_grant_mem ? mem_wdata_i : 32'h0;
    end else if (r_state == S_BUSY) begin
      if (r_cnt == 2'd0) begin
        r_state <= S_IDLE;
      end else begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (flush_i && !r_owner_mem) begin
        r_cancel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level reference model that
// tracks the SRAM as "busy until cycle N" and a byte-merged shadow memory.
module tb_sram_bus_arbiter;

  localparam int WS      = 2;
  localparam int MAX_LAT = 2 * (WS + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ack_o;
  logic [31:0] mem_rdata_o;
  logic        sram_ce_o;
  logic        sram_we_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.WAIT_STATES(WS)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_ack_o       (if_ack_o),
    .if_rdata_o     (if_rdata_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_sel_i      (mem_sel_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_ack_o      (mem_ack_o),
    .mem_rdata_o    (mem_rdata_o),
    .sram_ce_o      (sram_ce_o),
    .sram_we_o      (sram_we_o),
    .sram_sel_o     (sram_sel_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_rdata_i   (sram_rdata_i),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o)
  );

  // ---------------- SRAM device (1 KiB, word addressed by addr[9:2]) -------
  function automatic logic [31:0] seed_word(input int i);
    if (i == 64) return 32'h3C01ABCD;  // word at 0x100
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  logic [31:0] sram_mem [256];
  logic        preload;

  always_comb begin
    sram_rdata_i = 32'h0;
    if (sram_ce_o && !sram_we_o) sram_rdata_i = sram_mem[sram_addr_o[9:2]];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= seed_word(i);
    end else if (sram_ce_o && sram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (sram_sel_o[b]) sram_mem[sram_addr_o[9:2]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_owner_mem = 1'b0;
  bit          m_cancel = 1'b0;
  bit          m_we = 1'b0;
  int          m_ack_t = 0;
  logic [3:0]  m_sel = 4'h0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  bit          exp_if_done, exp_mem_done;

  task automatic model_step();
    bit          ack_cyc, busy, e_if_ack, e_mem_ack, e_we, mem_ok, if_ok;
    logic [31:0] rd;
    ack_cyc   = m_busy && (cyc == m_ack_t);
    busy      = m_busy && !rst;
    e_if_ack  = busy && ack_cyc && !m_owner_mem && !m_cancel && !flush_i;
    e_mem_ack = busy && ack_cyc && m_owner_mem;
    e_we      = busy && ack_cyc && m_we;
    rd        = ref_mem[m_addr[9:2]];

    check("sram_ce",    32'(sram_ce_o),  32'(busy));
    check("sram_we",    32'(sram_we_o),  32'(e_we));
    check("sram_addr",  sram_addr_o,     busy ? m_addr : 32'h0);
    check("sram_sel",   32'(sram_sel_o), busy ? 32'(m_sel) : 32'h0);
    check("sram_wdata", sram_wdata_o,    busy ? m_wdata : 32'h0);
    check("if_ack",     32'(if_ack_o),   32'(e_if_ack));
    check("if_rdata",   if_rdata_o,      e_if_ack ? rd : 32'h0);
    check("mem_ack",    32'(mem_ack_o),  32'(e_mem_ack));
    check("mem_rdata",  mem_rdata_o,     (e_mem_ack && !m_we) ? rd : 32'h0);
    check("stall_if",   32'(stallreq_if_o),  32'(!rst && if_req_i && !e_if_ack));
    check("stall_mem",  32'(stallreq_mem_o), 32'(!rst && mem_req_i && !e_mem_ack));

    exp_if_done  = rst || (busy && ack_cyc && !m_owner_mem);
    exp_mem_done = rst || e_mem_ack;

    if (rst) begin
      m_busy   = 1'b0;
      m_cancel = 1'b0;
    end else begin
      if (e_we)
        for (int b = 0; b < 4; b++)
          if (m_sel[b]) ref_mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
      if (m_busy && !m_owner_mem && flush_i) m_cancel = 1'b1;
      mem_ok = mem_req_i && !(ack_cyc && m_owner_mem);
      if_ok  = if_req_i && !(ack_cyc && !m_owner_mem);
      if ((!m_busy || ack_cyc) && !flush_i && (mem_ok || if_ok)) begin
        m_owner_mem = mem_ok;
        m_addr      = mem_ok ? mem_addr_i : if_addr_i;
        m_we        = mem_ok && mem_we_i;
        m_sel       = mem_ok ? mem_sel_i : 4'b1111;
        m_wdata     = mem_ok ? mem_wdata_i : 32'h0;
        m_busy      = 1'b1;
        m_cancel    = 1'b0;
        m_ack_t     = cyc + 1 + WS;
      end else if (ack_cyc) begin
        m_busy = 1'b0;
      end
    end
    cyc++;
  endtask

  // Observed outputs of the most recent cycle, for directed checks.
  logic        obs_ce, obs_we, obs_if_ack, obs_mem_ack, obs_stall_if;
  logic [31:0] obs_if_rdata, obs_mem_rdata;
  int          obs_cyc;

  // One clock cycle: sample at the falling edge, then move past the rising one.
  task automatic tick();
    @(negedge clk);
    obs_ce        = sram_ce_o;
    obs_we        = sram_we_o;
    obs_if_ack    = if_ack_o;
    obs_mem_ack   = mem_ack_o;
    obs_stall_if  = stallreq_if_o;
    obs_if_rdata  = if_rdata_o;
    obs_mem_rdata = mem_rdata_o;
    obs_cyc       = cyc;
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  task automatic idle_inputs();
    flush_i   = 1'b0;
    if_req_i  = 1'b0;
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
  endtask

  logic [31:0] old_word, exp_word;
  int          last_owner, if_start, n_if_acks, mism;

  initial begin
    rst         = 1'b1;
    preload     = 1'b1;
    flush_i     = 1'b0;
    if_req_i    = 1'b1;  // requests must be ignored while in reset
    if_addr_i   = 32'h0;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'hF;
    mem_addr_i  = 32'h0;
    mem_wdata_i = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    #1;
    tick();
    tick();
    rst     = 1'b0;
    preload = 1'b0;
    idle_inputs();
    tick();

    // ---- single fetch of 0x100 ----
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    for (int k = 0; k <= WS + 1; k++) begin
      tick();
      check("fetch_ce", 32'(obs_ce), 32'(k >= 1));
      check("fetch_stall", 32'(obs_stall_if), 32'(k != WS + 1));
      if (k == WS + 1) begin
        check("fetch_ack", 32'(obs_if_ack), 32'h1);
        check("fetch_data", obs_if_rdata, 32'h3C01ABCD);
        if_req_i = 1'b0;
      end
    end
    tick();

    // ---- contention: load 0x200 and fetch 0x104 together ----
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_sel_i  = 4'hF;
    mem_addr_i = 32'h200;
    if_req_i   = 1'b1;
    if_addr_i  = 32'h104;
    for (int k = 0; k <= 2 * WS + 2; k++) begin
      tick();
      check("cont_ce", 32'(obs_ce), 32'(k >= 1));
      check("cont_mem_ack", 32'(obs_mem_ack), 32'(k == WS + 1));
      check("cont_if_ack", 32'(obs_if_ack), 32'(k == 2 * WS + 2));
      if (k == WS + 1) begin
        check("cont_load_data", obs_mem_rdata, seed_word(128));
        mem_req_i = 1'b0;
      end
      if (k == 2 * WS + 2) if_req_i = 1'b0;
    end
    tick();

    // ---- byte store to 0x204 lane 1, then read back by fetch ----
    old_word    = ref_mem[8'h81];
    exp_word    = (old_word & 32'hFFFF00FF) | 32'h0000EE00;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_sel_i   = 4'b0010;
    mem_addr_i  = 32'h204;
    mem_wdata_i = 32'h0000EE00;
    for (int k = 0; k <= WS + 2; k++) begin
      tick();
      check("store_we", 32'(obs_we), 32'(k == WS + 1));
      if (k == WS + 1) begin
        check("store_ack", 32'(obs_mem_ack), 32'h1);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
      end
    end
    if_req_i  = 1'b1;
    if_addr_i = 32'h204;
    for (int k = 0; k <= WS + 1; k++) begin
      tick();
      if (k == WS + 1) begin
        check("readback_ack", 32'(obs_if_ack), 32'h1);
        check("readback_data", obs_if_rdata, exp_word);
        if_req_i = 1'b0;
      end
    end
    tick();

    // ---- flush during a fetch, then a new fetch of 0x180 ----
    if_req_i  = 1'b1;
    if_addr_i = 32'h140;
    for (int k = 0; k <= 2 * WS + 3; k++) begin
      tick();
      check("flush_ack", 32'(obs_if_ack), 32'(k == 2 * WS + 3));
      if (k == WS + 1) check("flush_ce_still", 32'(obs_ce), 32'h1);
      if (k == 2 * WS + 3) begin
        check("flush_new_data", obs_if_rdata, seed_word(96));
        if_req_i = 1'b0;
      end
      flush_i = (k == WS - 1);
      if (k == WS) if_req_i = 1'b0;
      if (k == WS + 1) begin
        if_req_i  = 1'b1;
        if_addr_i = 32'h180;
      end
    end
    tick();

    // ---- no starvation: both ports requesting continuously ----
    last_owner  = 0;
    n_if_acks   = 0;
    if_req_i    = 1'b1;
    if_addr_i   = rand_addr();
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'hF;
    mem_addr_i  = rand_addr();
    if_start    = cyc;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (obs_if_ack || obs_mem_ack) begin
        if (last_owner != 0)
          check("alternate", 32'(obs_if_ack ? 1 : 2), 32'(last_owner == 1 ? 2 : 1));
        last_owner = obs_if_ack ? 1 : 2;
      end
      if (obs_if_ack) begin
        n_if_acks++;
        check("if_latency", 32'(obs_cyc - if_start <= MAX_LAT), 32'h1);
      end
      if (exp_if_done) begin
        if_addr_i = rand_addr();
        if_start  = cyc;
      end
      if (exp_mem_done) mem_addr_i = rand_addr();
    end
    check("if_progress", 32'(n_if_acks >= 8), 32'h1);
    idle_inputs();
    tick();
    tick();

    // ---- reset in the first busy cycle of a store ----
    old_word    = ref_mem[8'hFC];
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_sel_i   = 4'hF;
    mem_addr_i  = 32'h3F0;
    mem_wdata_i = 32'hDEADBEEF;
    tick();
    check("rst_store_we0", 32'(obs_we), 32'h0);
    rst       = 1'b1;
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    tick();
    check("rst_store_we1", 32'(obs_we), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < WS + 2; k++) begin
      tick();
      check("rst_after_we", 32'(obs_we), 32'h0);
      check("rst_after_ce", 32'(obs_ce), 32'h0);
      check("rst_after_ack", 32'(obs_mem_ack | obs_if_ack), 32'h0);
    end
    check("rst_mem_unchanged", sram_mem[8'hFC], old_word);

    // ---- random traffic ----
    exp_if_done  = 1'b1;
    exp_mem_done = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      rst     = ($urandom_range(0, 299) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      if (!if_req_i || exp_if_done) begin
        if_req_i  = ($urandom_range(0, 3) != 0);
        if_addr_i = rand_addr();
      end
      if (!mem_req_i || exp_mem_done) begin
        mem_req_i   = ($urandom_range(0, 2) != 0);
        mem_we_i    = $urandom_range(0, 1) == 1;
        mem_sel_i   = 4'($urandom_range(1, 15));
        mem_addr_i  = rand_addr();
        mem_wdata_i = $urandom;
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < WS + 3; k++) tick();

    mism = 0;
    for (int i = 0; i < 256; i++) if (sram_mem[i] !== ref_mem[i]) mism++;
    check("final_memory_words", 32'(mism), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares one single-port data/instruction SRAM between the OpenMIPS fetch port (pc_reg/if_id side) and the MEM-stage load/store port. It sequences every access, with a configurable number of wait states. It grants the MEM port priority without starving fetch, and raises per-stage stall requests toward ctrl. It also drops a cancelled fetch on pipeline flush.

## Interface
Parameters:
- WAIT_STATES, 0: extra cycles each SRAM access is held; legal 0..3.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush from ctrl.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  32  fetch address.
- if_ack_o  out  1  fetch complete; one-cycle pulse.
- if_rdata_o  out  32  instruction; valid when if_ack_o=1, else 0.
- mem_req_i  in  1  load/store request; held until mem_ack_o.
- mem_we_i  in  1  1 = store.
- mem_sel_i  in  4  byte lanes.
- mem_addr_i  in  32  data address.
- mem_wdata_i  in  32  store data.
- mem_ack_o  out  1  load/store complete; one-cycle pulse.
- mem_rdata_o  out  32  load data; valid when mem_ack_o=1 and the access is a load, else 0.
- sram_ce_o  out  1  SRAM enable.
- sram_we_o  out  1  SRAM write strobe.
- sram_sel_o  out  4  SRAM byte lanes.
- sram_addr_o  out  32  SRAM address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data; combinational from address while ce=1 and we=0.
- stallreq_if_o  out  1  if_req_i & ~if_ack_o (combinational).
- stallreq_mem_o  out  1  mem_req_i & ~mem_ack_o (combinational).

## Operation
- States: IDLE and BUSY.
  - Registers: owner (IF/MEM), latched request fields, cnt[1:0], cancel flag.
- Arbitration happens in IDLE, and in the final (ack) cycle of BUSY.
  - Eligible requesters are those with req=1, excluding the requester being acked this cycle.
  - MEM beats IF when both are eligible.
  - No grant in any cycle with flush_i=1.
- Grant, at the clock edge:
  - Latch the address.
  - For MEM, latch we, sel and wdata. For IF, latch we=0 and sel=4'b1111.
  - Set owner, load cnt=WAIT_STATES, clear cancel, enter BUSY.
  - Request-input changes after the grant are ignored.
- BUSY:
  - sram_ce_o=1; addr/sel/wdata are driven from the latches.
  - cnt decrements each cycle.
  - The cycle with cnt==0 is the ack cycle.
  - sram_we_o=1 only in the ack cycle of a store, so each store commits exactly once, at the edge ending the ack cycle.
- Ack cycle:
  - The owner's ack_o=1.
  - For a load or fetch, rdata_o = sram_rdata_i.
  - Next state: BUSY for a new grant, otherwise IDLE.
- Flush:
  - flush_i=1 in any BUSY cycle of an IF-owned access sets cancel.
  - A cancelled fetch completes on the SRAM normally, but if_ack_o stays 0 in its ack cycle.
  - That cycle still counts as completion for exclusion and regrant.
  - MEM accesses are never cancelled.
- Starvation-free by construction: a MEM ack cycle excludes MEM, so a pending IF wins the next grant.

## Timing
- Reset values:
  - state IDLE, cnt 0, cancel 0.
  - All sram_* outputs 0.
  - if_ack_o, mem_ack_o, both rdata outputs and both stallreq outputs 0 (reqs are ignored while rst=1).
- Request first seen in IDLE at cycle t:
  - Grant at the edge ending t.
  - BUSY for cycles t+1 .. t+1+WAIT_STATES.
  - ack at t+1+WAIT_STATES; latency WAIT_STATES+1.
- Back-to-back: a different requester granted in an ack cycle is BUSY from the next cycle, so the SRAM has no idle cycle.
- Same requester: its next request is observable one cycle after its ack at the earliest.
- Reset mid-access:
  - Access abandoned, no ack.
  - A store not yet in its ack cycle is not written.
- Simultaneous flush_i and ack cycle on an IF access: if_ack_o=0.
- Simultaneous flush_i and pending MEM in IDLE: no grant that cycle; grant on the first cycle with flush_i=0.

## Test plan
- Single fetch, WAIT_STATES=1. if_req_i=1, if_addr_i=0x100 in cycle 0; SRAM word 0x3C01ABCD.
  - sram_ce_o=1 and sram_addr_o=0x100 in cycles 1–2.
  - if_ack_o=1 and if_rdata_o=0x3C01ABCD in cycle 2.
  - stallreq_if_o=1 in cycles 0–1, 0 in cycle 2.
- Contention, WAIT_STATES=0. if_req_i and mem_req_i (load 0x200) both rise in cycle 0.
  - MEM BUSY/ack in cycle 1; IF BUSY/ack in cycle 2.
  - sram_ce_o continuous for cycles 1–2.
- Store byte. mem_we_i=1, sel=4'b0010, addr 0x204, wdata 0x0000EE00, WAIT_STATES=2.
  - sram_we_o=1 only in cycle 3.
  - Read-back via fetch of 0x204 returns byte1=0xEE, other bytes unchanged.
- Flush during fetch, WAIT_STATES=2. flush_i=1 in cycle 2 of an IF access.
  - No if_ack_o in cycle 3.
  - New if_req_i (0x180) in cycle 4 is acked in cycle 7.
- No starvation. mem_req_i held high continuously with a new load after every ack; if_req_i high.
  - IF and MEM acks strictly alternate.
  - Every IF request is acked within 2×(WAIT_STATES+1) cycles.
- Reset mid-store. rst=1 in cycle 1 of a WAIT_STATES=2 store.
  - sram_we_o never asserts.
  - All outputs 0 in the cycle after rst; memory unchanged.
